// File: rtl/clock12_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock12_ctrl
//  Purpose  : 12-hour wall-clock time keeper with a three-state set mode.
//             RUN counts seconds on the 1 Hz TICK enable and carries them
//             through minutes, hours and the AM/PM flag. SET_H and SET_M let
//             the user step the hour or minute field with the INC button.
//             An optional idle timeout returns to RUN when no button has
//             been pressed for AUTO_EXIT ticks.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    AUTO_EXIT   idle ticks in a set state before returning to RUN
//                (0..255, 0 disables the timeout)
//  Ports
//    clk         input   1  sole clock, rising edge
//    rst_n       input   1  asynchronous active-low reset
//    tick_i      input   1  1 Hz enable, one clk cycle wide
//    mode_i      input   1  debounced mode button pulse
//    inc_i       input   1  debounced increment button pulse
//    hour_o      output  4  hour 0..11
//    min_o       output  6  minute 0..59
//    sec_o       output  6  second 0..59
//    pm_o        output  1  0 = AM, 1 = PM
//    setmode_o   output  2  00 RUN, 01 SET_H, 10 SET_M
//    blink_o     output  1  blink phase of the field being set
// ============================================================================
module clock12_ctrl #(
    parameter int unsigned AUTO_EXIT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       mode_i,
    input  logic       inc_i,
    output logic [3:0] hour_o,
    output logic [5:0] min_o,
    output logic [5:0] sec_o,
    output logic       pm_o,
    output logic [1:0] setmode_o,
    output logic       blink_o
);

    // State encoding doubles as the SETMODE output code.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10
    } state_t;

    localparam logic [7:0] C_AUTO_EXIT = AUTO_EXIT[7:0];
    localparam logic       C_AUTO_EN   = (AUTO_EXIT != 0);
    localparam logic [3:0] C_HOUR_MAX  = 4'd11;
    localparam logic [5:0] C_MS_MAX    = 6'd59;
    localparam logic [7:0] C_IDLE_MAX  = 8'd255;

    state_t     state_q, state_d;
    logic [3:0] hour_q,  hour_d;
    logic [5:0] min_q,   min_d;
    logic [5:0] sec_q,   sec_d;
    logic       pm_q,    pm_d;
    logic       blink_q, blink_d;
    logic [7:0] idle_q,  idle_d;

    // Value the idle counter would take on this tick (saturating).
    logic [7:0] w_idle_inc;
    logic       w_auto_hit;

    assign w_idle_inc = (idle_q == C_IDLE_MAX) ? C_IDLE_MAX : idle_q + 8'd1;
    assign w_auto_hit = C_AUTO_EN && (w_idle_inc == C_AUTO_EXIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pm_d    = pm_q;
        blink_d = blink_q;
        idle_d  = idle_q;

        case (state_q)
            ST_RUN: begin
                // Time keeps running even when MODE arrives on the same
                // edge; INC has no meaning here and is dropped.
                if (tick_i) begin
                    if (sec_q == C_MS_MAX) begin
                        sec_d = 6'd0;
                        if (min_q == C_MS_MAX) begin
                            min_d = 6'd0;
                            if (hour_q == C_HOUR_MAX) begin
                                hour_d = 4'd0;
                                pm_d   = ~pm_q;
                            end else begin
                                hour_d = hour_q + 4'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (mode_i) begin
                    state_d = ST_SET_H;
                end
            end

            ST_SET_H: begin
                if (mode_i) begin
                    // MODE wins over a coincident INC.
                    state_d = ST_SET_M;
                end else begin
                    if (inc_i) begin
                        idle_d = 8'd0;
                        if (hour_q == C_HOUR_MAX) begin
                            hour_d = 4'd0;
                            pm_d   = ~pm_q;
                        end else begin
                            hour_d = hour_q + 4'd1;
                        end
                    end else if (tick_i) begin
                        idle_d = w_idle_inc;
                        if (w_auto_hit) begin
                            // Leaving the hour field keeps the seconds.
                            state_d = ST_RUN;
                        end
                    end
                    if (tick_i) begin
                        blink_d = ~blink_q;
                    end
                end
            end

            ST_SET_M: begin
                if (mode_i) begin
                    state_d = ST_RUN;
                    sec_d   = 6'd0;
                end else begin
                    if (inc_i) begin
                        idle_d = 8'd0;
                        // Minute wraps locally; the hour is left alone.
                        min_d  = (min_q == C_MS_MAX) ? 6'd0 : min_q + 6'd1;
                    end else if (tick_i) begin
                        idle_d = w_idle_inc;
                        if (w_auto_hit) begin
                            state_d = ST_RUN;
                            sec_d   = 6'd0;
                        end
                    end
                    if (tick_i) begin
                        blink_d = ~blink_q;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Every state entry starts a fresh idle window with the display lit.
        if (state_d != state_q) begin
            idle_d  = 8'd0;
            blink_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            hour_q  <= 4'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            pm_q    <= 1'b0;
            blink_q <= 1'b0;
            idle_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            pm_q    <= pm_d;
            blink_q <= blink_d;
            idle_q  <= idle_d;
        end
    end

    assign hour_o    = hour_q;
    assign min_o     = min_q;
    assign sec_o     = sec_q;
    assign pm_o      = pm_q;
    assign setmode_o = state_q;
    assign blink_o   = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clock12_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock12_ctrl
//  Purpose  : Directed self-checking bench for clock12_ctrl (AUTO_EXIT=10).
//             Inputs change on the falling edge, outputs are checked on the
//             falling edge after the rising edge that consumed them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock12_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_i;
    logic       mode_i;
    logic       inc_i;
    logic [3:0] hour_o;
    logic [5:0] min_o;
    logic [5:0] sec_o;
    logic       pm_o;
    logic [1:0] setmode_o;
    logic       blink_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clock12_ctrl #(
        .AUTO_EXIT (10)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_i),
        .mode_i    (mode_i),
        .inc_i     (inc_i),
        .hour_o    (hour_o),
        .min_o     (min_o),
        .sec_o     (sec_o),
        .pm_o      (pm_o),
        .setmode_o (setmode_o),
        .blink_o   (blink_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle with the given button/tick levels, ending on a falling edge.
    task automatic step(input logic t, input logic m, input logic i);
        tick_i = t;
        mode_i = m;
        inc_i  = i;
        @(posedge clk);
        @(negedge clk);
        tick_i = 1'b0;
        mode_i = 1'b0;
        inc_i  = 1'b0;
    endtask

    task automatic steps(input int n, input logic t, input logic m, input logic i);
        for (int k = 0; k < n; k++) step(t, m, i);
    endtask

    task automatic check_all(input string tag, input int h, input int m,
                             input int s, input int p, input int sm, input int b);
        check_eq({tag, ".hour"},    32'(hour_o),    32'(h));
        check_eq({tag, ".min"},     32'(min_o),     32'(m));
        check_eq({tag, ".sec"},     32'(sec_o),     32'(s));
        check_eq({tag, ".pm"},      32'(pm_o),      32'(p));
        check_eq({tag, ".setmode"}, 32'(setmode_o), 32'(sm));
        check_eq({tag, ".blink"},   32'(blink_o),   32'(b));
    endtask

    initial begin
        // ---------------- reset, with inputs active that must be lost
        rst_n  = 1'b0;
        tick_i = 1'b1;
        mode_i = 1'b1;
        inc_i  = 1'b1;
        repeat (3) @(negedge clk);
        check_all("rst_hold", 0, 0, 0, 0, 0, 0);
        tick_i = 1'b0;
        mode_i = 1'b0;
        inc_i  = 1'b0;
        rst_n  = 1'b1;
        step(0, 0, 0);
        check_all("rst_rel", 0, 0, 0, 0, 0, 0);

        // ---------------- full rollover
        step(0, 1, 0);
        check_eq("roll.enter_seth", 32'(setmode_o), 32'd1);
        steps(11, 0, 0, 1);
        check_eq("roll.hour11", 32'(hour_o), 32'd11);
        check_eq("roll.pm_am",  32'(pm_o),   32'd0);
        step(0, 1, 0);
        check_eq("roll.enter_setm", 32'(setmode_o), 32'd2);
        steps(59, 0, 0, 1);
        check_eq("roll.min59", 32'(min_o), 32'd59);
        step(0, 1, 0);
        check_all("roll.run", 11, 59, 0, 0, 0, 0);
        steps(59, 1, 0, 0);
        check_all("roll.sec59", 11, 59, 59, 0, 0, 0);
        step(1, 0, 0);
        check_all("roll.wrap", 0, 0, 0, 1, 0, 0);

        // ---------------- INC ignored in RUN; TICK+MODE both act
        step(0, 0, 1);
        check_all("run_inc", 0, 0, 0, 1, 0, 0);
        steps(16, 1, 0, 0);
        step(1, 1, 0);
        check_all("tick_mode", 0, 0, 17, 1, 1, 0);

        // ---------------- MODE+INC conflict in SET_H
        steps(3, 0, 0, 1);
        check_eq("conf.hour3", 32'(hour_o), 32'd3);
        step(0, 1, 1);
        check_eq("conf.setmode", 32'(setmode_o), 32'd2);
        check_eq("conf.hour",    32'(hour_o),    32'd3);

        // ---------------- minute wrap inside SET_M does not carry
        steps(59, 0, 0, 1);
        check_eq("mwrap.min59", 32'(min_o), 32'd59);
        step(0, 0, 1);
        check_all("mwrap", 3, 0, 17, 1, 2, 0);

        // ---------------- auto-exit from SET_M
        steps(9, 1, 0, 0);
        check_all("auto.t9", 3, 0, 17, 1, 2, 1);
        step(0, 0, 1);
        check_all("auto.inc", 3, 1, 17, 1, 2, 1);
        steps(9, 1, 0, 0);
        check_all("auto.t9b", 3, 1, 17, 1, 2, 0);
        step(1, 0, 0);
        check_all("auto.exit", 3, 1, 0, 1, 0, 0);

        // ---------------- auto-exit from SET_H keeps seconds
        steps(5, 1, 0, 0);
        step(0, 1, 0);
        steps(9, 1, 0, 0);
        check_all("autoh.t9", 3, 1, 5, 1, 1, 1);
        step(1, 0, 0);
        check_all("autoh.exit", 3, 1, 5, 1, 0, 0);

        // ---------------- TICK in SET_H only toggles BLINK
        steps(37, 1, 0, 0);
        step(0, 1, 0);
        check_all("tickset.enter", 3, 1, 42, 1, 1, 0);
        step(1, 0, 0);
        check_all("tickset.tick", 3, 1, 42, 1, 1, 1);
        step(0, 1, 0);
        check_all("tickset.to_m", 3, 1, 42, 1, 2, 0);
        step(0, 1, 0);
        check_all("tickset.exit", 3, 1, 0, 1, 0, 0);

        // ---------------- asynchronous reset in SET_M
        step(0, 1, 0);
        steps(2, 0, 0, 1);
        step(0, 1, 0);
        steps(29, 0, 0, 1);
        check_all("arst.pre", 5, 30, 0, 1, 2, 0);
        rst_n = 1'b0;
        #1;
        check_all("arst.now", 0, 0, 0, 0, 0, 0);
        tick_i = 1'b1;
        repeat (2) @(negedge clk);
        tick_i = 1'b0;
        check_eq("arst.tick_lost", 32'(sec_o), 32'd0);
        rst_n = 1'b1;
        step(1, 0, 0);
        check_all("arst.first_edge", 0, 0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
